// File: rtl/alu_share_sequencer.sv
// Two-requester round-robin front end for one shared W-bit ALU (add/sub/mul/div/shl/shr, 2W-bit result).
// Optional per-requester response counters are enabled by defining ALU_SHARE_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for a request handshake; only state where req_ready can be non-zero
// EXEC   | single-cycle ALU evaluation, or divider setup for a non-zero divisor
// DIV    | restoring divide, one quotient bit per cycle, MSB first
// RESP   | response presented and held until resp_ready
module alu_share_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2:0]         req_op0,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [2:0]         req_op1,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_result,
  output logic               resp_err,
  output logic               busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]        done_cnt0,
  output logic [15:0]        done_cnt1
`endif
);

  localparam int R  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             last_grant;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    div_cnt_q;

  logic             handshake;
  logic             grant_id;
  logic             div_go;
  logic             div_last;

  logic [R-1:0]     ext_a;
  logic [R-1:0]     ext_b;
  logic [R-1:0]     alu_result;
  logic             alu_err;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign grant_id = req_ready[1];
  assign div_go   = (op_q == OP_DIV) && (b_q != '0);
  assign div_last = (div_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    handshake  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        case (req_valid)
          2'b01:   req_ready = 2'b01;
          2'b10:   req_ready = 2'b10;
          2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
          default: req_ready = 2'b00;
        endcase
        handshake = |(req_valid & req_ready);
        if (handshake) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = div_go ? S_DIV : S_RESP;
      end
      S_DIV: begin
        if (div_last) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ext_a = {{WIDTH{1'b0}}, a_q};
  assign ext_b = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (op_q)
      OP_ADD: alu_result = ext_a + ext_b;
      OP_SUB: alu_result = ext_a - ext_b;
      OP_MUL: alu_result = ext_a * ext_b;
      OP_DIV: begin
        // Only the divide-by-zero result is taken from here; real divides go through DIV.
        if (b_q == '0) begin
          alu_result = '1;
          alu_err    = 1'b1;
        end
      end
      OP_SHL: alu_result = ext_a << b_q;
      OP_SHR: alu_result = ext_a >> b_q;
      default: alu_err = 1'b1;
    endcase
  end

  // Partial remainder stays below b, so the shifted value needs one extra bit
  // and the trial subtraction's MSB is the borrow.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign rem_nxt   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      rem_q       <= '0;
      quo_q       <= '0;
      div_cnt_q   <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (handshake) begin
        op_q       <= grant_id ? req_op1 : req_op0;
        a_q        <= grant_id ? req_a1 : req_a0;
        b_q        <= grant_id ? req_b1 : req_b0;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == S_EXEC) begin
        if (div_go) begin
          rem_q     <= '0;
          quo_q     <= a_q;
          div_cnt_q <= DIV_LAST_CNT;
        end else begin
          resp_result <= alu_result;
          resp_err    <= alu_err;
          resp_id     <= id_q;
        end
      end
      if (state == S_DIV) begin
        rem_q     <= rem_nxt;
        quo_q     <= quo_nxt;
        div_cnt_q <= div_cnt_q - CW'(1);
        if (div_last) begin
          resp_result <= {rem_nxt, quo_nxt};
          resp_err    <= 1'b0;
          resp_id     <= id_q;
        end
      end
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_id) begin
        done_cnt1 <= done_cnt1 + 16'd1;
      end else begin
        done_cnt0 <= done_cnt0 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed bench for alu_share_sequencer (WIDTH=4): vector table plus arbitration, stall and abort sequences.
module tb_alu_share_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [2:0]   req_op0 = '0, req_op1 = '0;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic         resp_id;
  logic [2*W-1:0] resp_result;
  logic         resp_err;
  logic         busy;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0]  done_cnt0, done_cnt1;
`endif

  alu_share_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
`ifdef ALU_SHARE_STATS_EN
    , .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[14];
  int tests = 0;
  int fails = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end
  endtask

  // Called in the cycle after the handshake; cyc = extra cycles waited.
  task automatic wait_resp(input string name, input logic [7:0] er, input logic ee,
                           input logic eid, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({name, ".valid"}, 32'(resp_valid), 32'd1);
    check({name, ".result"}, 32'(resp_result), 32'(er));
    check({name, ".err"}, 32'(resp_err), 32'(ee));
    check({name, ".id"}, 32'(resp_id), 32'(eid));
    if (resp_valid && resp_ready) begin
      if (eid) exp_cnt1++;
      else exp_cnt0++;
    end
  endtask

  task automatic do_op(input string name, input vec_t v);
    int n;
    int cyc;
    drive_req(v.id, v.op, v.a, v.b);
    req_valid[v.id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[v.id] && n < 20) begin
      tick();
      n++;
    end
    check({name, ".grant"}, 32'(req_ready[v.id]), 32'd1);
    tick();
    req_valid[v.id] = 1'b0;
    wait_resp(name, v.res, v.err, v.id[0], cyc);
    check({name, ".latency"}, 32'(cyc + 1), 32'(v.lat));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit stable;
    bit saw_valid;

    vecs[0]  = '{0, 3'd0, 4'd9,  4'd8,  8'h11, 1'b0, 2};
    vecs[1]  = '{1, 3'd3, 4'd13, 4'd4,  8'h13, 1'b0, 6};
    vecs[2]  = '{0, 3'd3, 4'd7,  4'd0,  8'hFF, 1'b1, 2};
    vecs[3]  = '{0, 3'd6, 4'd5,  4'd5,  8'h00, 1'b1, 2};
    vecs[4]  = '{1, 3'd4, 4'd15, 4'd6,  8'hC0, 1'b0, 2};
    vecs[5]  = '{0, 3'd5, 4'd12, 4'd2,  8'h03, 1'b0, 2};
    vecs[6]  = '{1, 3'd7, 4'd15, 4'd15, 8'h00, 1'b1, 2};
    vecs[7]  = '{0, 3'd1, 4'd0,  4'd1,  8'hFF, 1'b0, 2};
    vecs[8]  = '{1, 3'd3, 4'd15, 4'd1,  8'h0F, 1'b0, 6};
    vecs[9]  = '{0, 3'd3, 4'd3,  4'd7,  8'h30, 1'b0, 6};
    vecs[10] = '{1, 3'd2, 4'd15, 4'd15, 8'hE1, 1'b0, 2};
    vecs[11] = '{0, 3'd4, 4'd15, 4'd15, 8'h00, 1'b0, 2};
    vecs[12] = '{1, 3'd3, 4'd15, 4'd15, 8'h01, 1'b0, 6};
    vecs[13] = '{0, 3'd2, 4'd12, 4'd11, 8'h84, 1'b0, 2};

    // Reset values
    tick(); tick();
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_result", 32'(resp_result), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_id", 32'(resp_id), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle.req_ready", 32'(req_ready), 32'd0);

    // Contention from reset: req0 wins first, req1 next
    drive_req(0, 3'd1, 4'd3, 4'd5);
    drive_req(1, 3'd2, 4'd15, 4'd15);
    req_valid = 2'b11;
    #1;
    check("cont.first_grant", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    check("cont.busy", 32'(busy), 32'd1);
    check("cont.ready_busy", 32'(req_ready), 32'd0);
    wait_resp("cont.r0", 8'hFE, 1'b0, 1'b0, cyc);
    tick();
    check("cont.second_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    wait_resp("cont.r1", 8'hE1, 1'b0, 1'b1, cyc);
    tick();

    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Response stall: outputs hold, no grants; afterwards round robin picks req1
    resp_ready = 1'b0;
    drive_req(0, 3'd4, 4'd15, 4'd6);
    req_valid = 2'b01;
    #1;
    check("hold.grant", 32'(req_ready), 32'b01);
    tick();
    drive_req(1, 3'd5, 4'd12, 4'd2);
    req_valid = 2'b11;
    wait_resp("hold.r0", 8'hC0, 1'b0, 1'b0, cyc);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!resp_valid || resp_result !== 8'hC0 || resp_err !== 1'b0 || req_ready !== 2'b00) stable = 1'b0;
    end
    check("hold.stable", 32'(stable), 32'd1);
    resp_ready = 1'b1;
    exp_cnt0++;
    #1;
    check("hold.no_accept_in_resp", 32'(req_ready), 32'd0);
    tick();
    check("hold.rr_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    wait_resp("hold.r1", 8'h03, 1'b0, 1'b1, cyc);
    tick();

    // Requester drops valid before being granted: nothing latched
    drive_req(0, 3'd0, 4'd1, 4'd1);
    req_valid = 2'b01;
    #1;
    check("drop.grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    drive_req(1, 3'd0, 4'd2, 4'd2);
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    wait_resp("drop.r0", 8'h02, 1'b0, 1'b0, cyc);
    tick(); tick();
    check("drop.idle_after", 32'(busy), 32'd0);

`ifdef ALU_SHARE_STATS_EN
    check("stats.cnt0", 32'(done_cnt0), 32'(exp_cnt0));
    check("stats.cnt1", 32'(done_cnt1), 32'(exp_cnt1));
`endif

    // Reset in the 2nd DIV cycle aborts the divide (req0, so last_grant=0 before reset)
    drive_req(0, 3'd3, 4'd13, 4'd4);
    req_valid = 2'b01;
    #1;
    check("abort.grant", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    saw_valid = resp_valid;
    tick();
    saw_valid |= resp_valid;
    tick();
    saw_valid |= resp_valid;
    rst = 1'b1;
    tick();
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.resp_result", 32'(resp_result), 32'd0);
`ifdef ALU_SHARE_STATS_EN
    check("abort.cnt0", 32'(done_cnt0), 32'd0);
    check("abort.cnt1", 32'(done_cnt1), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_valid |= resp_valid;
    end
    check("abort.no_resp", 32'(saw_valid), 32'd0);
    drive_req(0, 3'd0, 4'd1, 4'd2);
    drive_req(1, 3'd0, 4'd3, 4'd4);
    req_valid = 2'b11;
    #1;
    check("abort.next_grant", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    tick();
    check("abort.idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
